// File: rtl/matrix_op_sequencer.sv
// -----------------------------------------------------------------------------
// matrix_op_sequencer
//
// Sequences one matrix instruction at a time against a single-port 256-bit RAM:
// read source A, optionally read source B, capture the datapath result, write
// it back to the destination word, then pulse done. Opcode 11 is rejected
// without touching the RAM and raises a sticky error flag.
//
// Ports
//   clk            single clock, all logic on the rising edge
//   reset          synchronous, active-high reset
//   instr_valid    requester presents an instruction
//   instr_ready    sequencer can accept an instruction (IDLE only)
//   opcode         00 sum, 01 subtract, 10 copy A, 11 illegal
//   addr_a/_b/_c   source A, source B and destination RAM words
//   mem_address    RAM address (0 when not accessing the RAM)
//   mem_wren       RAM write enable (WRITE state only)
//   mem_wdata      RAM write data, always the result register
//   mem_rdata      RAM read data, valid RD_LAT cycles after the address
//   matrix_a/_b    registered operands to the external sum/subtract datapath
//   alu_sum/_sub   combinational results from that datapath
//   busy           high in every state except IDLE
//   done           high for the single DONE cycle
//   error          set by an illegal instruction, cleared by the next legal one
//   leds           low byte of the last written result
// -----------------------------------------------------------------------------
module matrix_op_sequencer #(
    parameter int RD_LAT = 1    // RAM read latency in cycles, 1..3
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         instr_valid,
    output logic         instr_ready,
    input  logic [1:0]   opcode,
    input  logic [7:0]   addr_a,
    input  logic [7:0]   addr_b,
    input  logic [7:0]   addr_c,
    output logic [7:0]   mem_address,
    output logic         mem_wren,
    output logic [255:0] mem_wdata,
    input  logic [255:0] mem_rdata,
    output logic [255:0] matrix_a,
    output logic [255:0] matrix_b,
    input  logic [255:0] alu_sum,
    input  logic [255:0] alu_sub,
    output logic         busy,
    output logic         done,
    output logic         error,
    output logic [7:0]   leds
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RD_A  = 3'd1,
        RD_B  = 3'd2,
        EXEC  = 3'd3,
        WRITE = 3'd4,
        DONE  = 3'd5
    } state_t;

    localparam logic [1:0] OP_SUM     = 2'b00;
    localparam logic [1:0] OP_SUB     = 2'b01;
    localparam logic [1:0] OP_COPY    = 2'b10;
    localparam logic [1:0] OP_ILLEGAL = 2'b11;

    // Each read state holds its address for RD_LAT+1 cycles; the data for that
    // address is present on mem_rdata in the last of them.
    localparam logic [1:0] LAST_CNT = 2'(RD_LAT);

    state_t         state, state_next;
    logic [1:0]     rd_cnt;
    logic           rd_last;
    logic           accept;

    logic [1:0]     op_q;
    logic [7:0]     addr_a_q, addr_b_q, addr_c_q;
    logic [255:0]   result;

    assign instr_ready = (state == IDLE) && !reset;
    assign accept      = instr_valid && instr_ready;
    assign rd_last     = (rd_cnt == LAST_CNT);
    assign mem_wdata   = result;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of block order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        state_next  = state;
        mem_address = 8'd0;
        mem_wren    = 1'b0;
        busy        = 1'b1;
        done        = 1'b0;

        unique case (state)
            IDLE: begin
                busy = 1'b0;
                if (accept) begin
                    state_next = (opcode == OP_ILLEGAL) ? DONE : RD_A;
                end
            end
            RD_A: begin
                mem_address = addr_a_q;
                if (rd_last) begin
                    state_next = (op_q == OP_COPY) ? EXEC : RD_B;
                end
            end
            RD_B: begin
                mem_address = addr_b_q;
                if (rd_last) begin
                    state_next = EXEC;
                end
            end
            EXEC: begin
                state_next = WRITE;
            end
            WRITE: begin
                mem_address = addr_c_q;
                mem_wren    = 1'b1;
                state_next  = DONE;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_cnt   <= 2'd0;
            op_q     <= OP_SUM;
            addr_a_q <= 8'd0;
            addr_b_q <= 8'd0;
            addr_c_q <= 8'd0;
            matrix_a <= '0;
            matrix_b <= '0;
            result   <= '0;
            leds     <= 8'd0;
            error    <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    rd_cnt <= 2'd0;
                    if (accept) begin
                        op_q     <= opcode;
                        addr_a_q <= addr_a;
                        addr_b_q <= addr_b;
                        addr_c_q <= addr_c;
                        // Sticky until the next accept decides it again.
                        error    <= (opcode == OP_ILLEGAL);
                    end
                end
                RD_A: begin
                    if (rd_last) begin
                        rd_cnt   <= 2'd0;
                        matrix_a <= mem_rdata;
                    end else begin
                        rd_cnt <= rd_cnt + 2'd1;
                    end
                end
                RD_B: begin
                    if (rd_last) begin
                        rd_cnt   <= 2'd0;
                        matrix_b <= mem_rdata;
                    end else begin
                        rd_cnt <= rd_cnt + 2'd1;
                    end
                end
                EXEC: begin
                    unique case (op_q)
                        OP_SUM:  result <= alu_sum;
                        OP_SUB:  result <= alu_sub;
                        default: result <= matrix_a;
                    endcase
                end
                WRITE: begin
                    leds <= result[7:0];
                end
                default: begin
                    rd_cnt <= 2'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_matrix_op_sequencer.sv
// -----------------------------------------------------------------------------
// tb_matrix_op_sequencer
//
// Three sequencers (RD_LAT = 1, 2, 3) share clock, reset and instruction
// fields; each has its own RAM model with matching read latency and its own
// sum/subtract datapath. Directed steps with hand-computed expectations.
// -----------------------------------------------------------------------------
module tb_matrix_op_sequencer;

    logic         clk = 1'b0;
    logic         reset;
    logic [1:0]   opcode;
    logic [7:0]   addr_a, addr_b, addr_c;

    logic         instr_valid [3];
    logic         instr_ready [3];
    logic [7:0]   mem_address [3];
    logic         mem_wren    [3];
    logic [255:0] mem_wdata   [3];
    logic [255:0] mem_rdata   [3];
    logic [255:0] matrix_a    [3];
    logic [255:0] matrix_b    [3];
    logic         busy        [3];
    logic         done        [3];
    logic         error       [3];
    logic [7:0]   leds        [3];

    // Back-door preload port into the RAM models.
    logic         pre_we [3];
    logic [7:0]   pre_addr;
    logic [255:0] pre_data;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    genvar g;
    generate
        for (g = 0; g < 3; g++) begin : g_inst
            logic [255:0] ram  [256];
            logic [255:0] pipe [3];
            logic [255:0] alu_sum, alu_sub;

            assign alu_sum      = matrix_a[g] + matrix_b[g];
            assign alu_sub      = matrix_a[g] - matrix_b[g];
            assign mem_rdata[g] = pipe[g];   // latency g+1

            always @(posedge clk) begin
                pipe[0] <= ram[mem_address[g]];
                pipe[1] <= pipe[0];
                pipe[2] <= pipe[1];
                if (pre_we[g]) ram[pre_addr] <= pre_data;
                else if (mem_wren[g]) ram[mem_address[g]] <= mem_wdata[g];
            end

            matrix_op_sequencer #(.RD_LAT(g + 1)) dut (
                .clk         (clk),
                .reset       (reset),
                .instr_valid (instr_valid[g]),
                .instr_ready (instr_ready[g]),
                .opcode      (opcode),
                .addr_a      (addr_a),
                .addr_b      (addr_b),
                .addr_c      (addr_c),
                .mem_address (mem_address[g]),
                .mem_wren    (mem_wren[g]),
                .mem_wdata   (mem_wdata[g]),
                .mem_rdata   (mem_rdata[g]),
                .matrix_a    (matrix_a[g]),
                .matrix_b    (matrix_b[g]),
                .alu_sum     (alu_sum),
                .alu_sub     (alu_sub),
                .busy        (busy[g]),
                .done        (done[g]),
                .error       (error[g]),
                .leds        (leds[g])
            );
        end
    endgenerate

    function automatic logic [255:0] ram_word(input int inst, input logic [7:0] a);
        case (inst)
            0:       return g_inst[0].ram[a];
            1:       return g_inst[1].ram[a];
            default: return g_inst[2].ram[a];
        endcase
    endfunction

    task automatic check(input string tag, input logic [255:0] observed, input logic [255:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Inputs change 1 time unit after the rising edge, outputs sampled there too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input int inst, input logic [7:0] a, input logic [255:0] d);
        pre_addr     = a;
        pre_data     = d;
        pre_we[inst] = 1'b1;
        tick();
        pre_we[inst] = 1'b0;
    endtask

    // Presents one instruction, waits for the accept, scrambles the instruction
    // fields afterwards, and counts cycles after the accept edge until done.
    task automatic run_op(input int inst, input logic [1:0] op,
                          input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                          input bit toggle,
                          output int waits, output int cycles,
                          output bit wren_seen, output logic err1);
        opcode            = op;
        addr_a            = a;
        addr_b            = b;
        addr_c            = c;
        instr_valid[inst] = 1'b1;
        waits             = 0;
        while (!instr_ready[inst] && waits < 20) begin
            tick();
            waits++;
        end
        tick();
        instr_valid[inst] = 1'b0;
        opcode            = 2'b11;
        addr_a            = 8'hFF;
        addr_b            = 8'hFE;
        addr_c            = 8'hFD;
        cycles            = 1;
        wren_seen         = mem_wren[inst];
        err1              = error[inst];
        while (!done[inst] && cycles < 40) begin
            if (toggle) instr_valid[inst] = ~instr_valid[inst];
            tick();
            cycles++;
            wren_seen = wren_seen | mem_wren[inst];
        end
        instr_valid[inst] = 1'b0;
        if (!done[inst]) cycles = -1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        int   waits, cycles;
        bit   wren_seen;
        logic err1;

        reset    = 1'b1;
        opcode   = 2'b00;
        addr_a   = 8'd0;
        addr_b   = 8'd0;
        addr_c   = 8'd0;
        pre_addr = 8'd0;
        pre_data = '0;
        for (int i = 0; i < 3; i++) begin
            instr_valid[i] = 1'b0;
            pre_we[i]      = 1'b0;
        end

        // Reset state.
        tick();
        tick();
        check("rst_busy",        busy[0],        0);
        check("rst_done",        done[0],        0);
        check("rst_error",       error[0],       0);
        check("rst_leds",        leds[0],        0);
        check("rst_wren",        mem_wren[0],    0);
        check("rst_addr",        mem_address[0], 0);
        check("rst_ready_low",   instr_ready[0], 0);
        check("rst_matrix_a",    matrix_a[0],    0);
        reset = 1'b0;
        tick();
        check("idle_ready",      instr_ready[0], 1);

        for (int i = 0; i < 3; i++) begin
            preload(i, 8'd1, {32{8'h01}});
            preload(i, 8'd2, {32{8'h02}});
        end

        // Sum, RD_LAT=1: 01.. + 02.. -> 03.. in RAM[3], done in cycle 7.
        run_op(0, 2'b00, 8'd1, 8'd2, 8'd3, 1'b0, waits, cycles, wren_seen, err1);
        check("sum_done_cycle",  cycles,          7);
        check("sum_leds",        leds[0],         8'h03);
        check("sum_wren_seen",   wren_seen,       1);
        check("sum_error",       error[0],        0);
        tick();
        check("sum_ram3",        ram_word(0, 8'd3), {32{8'h03}});

        // Subtract, 02.. - 01.. -> 01.., accepted in the cycle right after DONE.
        run_op(0, 2'b01, 8'd2, 8'd1, 8'd3, 1'b0, waits, cycles, wren_seen, err1);
        check("sub_b2b_wait",    waits,           0);
        check("sub_done_cycle",  cycles,          7);
        check("sub_leds",        leds[0],         8'h01);
        tick();
        check("sub_ram3",        ram_word(0, 8'd3), {32{8'h01}});

        // Illegal opcode: DONE one cycle after accept, no RAM access, error set.
        run_op(0, 2'b11, 8'd1, 8'd2, 8'd4, 1'b0, waits, cycles, wren_seen, err1);
        check("ill_done_cycle",  cycles,          1);
        check("ill_error",       error[0],        1);
        check("ill_no_wren",     wren_seen,       0);
        check("ill_addr_zero",   mem_address[0],  0);
        check("ill_leds_kept",   leds[0],         8'h01);
        tick();
        check("ill_error_sticky", error[0],       1);

        // Copy A after illegal: clears error on accept, RD_B skipped.
        run_op(0, 2'b10, 8'd2, 8'd1, 8'd7, 1'b0, waits, cycles, wren_seen, err1);
        check("copy_err_cleared", err1,           0);
        check("copy_done_cycle", cycles,          5);
        check("copy_matrix_b",   matrix_b[0],     {32{8'h01}});
        check("copy_leds",       leds[0],         8'h02);
        tick();
        check("copy_ram7",       ram_word(0, 8'd7), {32{8'h02}});

        // In-place sum with instr_valid toggling while busy.
        preload(0, 8'd5, {32{8'h11}});
        preload(0, 8'd6, {32{8'h22}});
        run_op(0, 2'b00, 8'd5, 8'd6, 8'd5, 1'b1, waits, cycles, wren_seen, err1);
        check("inpl_done_cycle", cycles,          7);
        check("inpl_leds",       leds[0],         8'h33);
        tick();
        check("inpl_ram5",       ram_word(0, 8'd5), {32{8'h33}});
        check("inpl_no_queue_a", busy[0],         0);
        tick();
        check("inpl_no_queue_b", busy[0],         0);

        // Leave instance 1 with error set, to be cleared by reset below.
        run_op(1, 2'b11, 8'd0, 8'd0, 8'd0, 1'b0, waits, cycles, wren_seen, err1);
        check("ill1_error",      error[1],        1);

        // Reset asserted in EXEC: IDLE next cycle, no write to RAM[9].
        preload(0, 8'd9, {32{8'hAA}});
        opcode         = 2'b00;
        addr_a         = 8'd1;
        addr_b         = 8'd2;
        addr_c         = 8'd9;
        instr_valid[0] = 1'b1;
        tick();
        instr_valid[0] = 1'b0;
        check("rmid_busy",       busy[0],         1);
        check("rmid_ready_low",  instr_ready[0],  0);
        for (int i = 0; i < 4; i++) tick();
        reset = 1'b1;
        tick();
        check("rmid_busy_clr",   busy[0],         0);
        check("rmid_done_clr",   done[0],         0);
        check("rmid_leds_clr",   leds[0],         0);
        check("rmid_wren_clr",   mem_wren[0],     0);
        check("rmid_addr_clr",   mem_address[0],  0);
        check("rmid_ma_clr",     matrix_a[0],     0);
        check("rmid_mb_clr",     matrix_b[0],     0);
        check("rmid_ready_rst",  instr_ready[0],  0);
        check("rmid_err1_clr",   error[1],        0);
        reset = 1'b0;
        tick();
        tick();
        check("rmid_ram9_kept",  ram_word(0, 8'd9), {32{8'hAA}});

        // Sum with RD_LAT=2 and RD_LAT=3.
        run_op(1, 2'b00, 8'd1, 8'd2, 8'd3, 1'b0, waits, cycles, wren_seen, err1);
        check("lat2_done_cycle", cycles,          9);
        check("lat2_leds",       leds[1],         8'h03);
        tick();
        check("lat2_ram3",       ram_word(1, 8'd3), {32{8'h03}});

        run_op(2, 2'b00, 8'd1, 8'd2, 8'd3, 1'b0, waits, cycles, wren_seen, err1);
        check("lat3_done_cycle", cycles,          11);
        check("lat3_leds",       leds[2],         8'h03);
        tick();
        check("lat3_ram3",       ram_word(2, 8'd3), {32{8'h03}});

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
